// File: rtl/snitch_mem_arbiter_pkg.sv
// Shared types and constants for the Snitch fetch/data memory arbiter.
package snitch_mem_arbiter_pkg;

    localparam int unsigned DefAddrWidth = 32;
    localparam int unsigned DefDataWidth = 64;
    localparam int unsigned DefInstWidth = 32;
    localparam int unsigned AmoWidth     = 4;

    localparam logic [AmoWidth-1:0] AmoNone = 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        GNT_INST,
        GNT_DATA
    } state_e;

endpackage

// File: rtl/snitch_mem_rsp_reg.sv
// One-entry data response register; a pop and a push may happen in the same cycle.
module snitch_mem_rsp_reg #(
    parameter int unsigned DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push,
    input  logic [DataWidth-1:0] push_data,
    input  logic                 push_error,
    output logic [DataWidth-1:0] pdata,
    output logic                 perror,
    output logic                 pvalid,
    input  logic                 pready
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pvalid <= 1'b0;
            pdata  <= '0;
            perror <= 1'b0;
        end else if (push) begin
            pvalid <= 1'b1;
            pdata  <= push_data;
            perror <= push_error;
        end else if (pvalid && pready) begin
            pvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/snitch_mem_arbiter.sv
// Round-robin arbiter merging the Snitch fetch and data ports onto one memory port.
module snitch_mem_arbiter
    import snitch_mem_arbiter_pkg::*;
#(
    parameter int unsigned AddrWidth = DefAddrWidth,
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned InstWidth = DefInstWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [AddrWidth-1:0]   inst_addr_i,
    input  logic                   inst_valid_i,
    output logic [InstWidth-1:0]   inst_data_o,
    output logic                   inst_ready_o,
    input  logic [AddrWidth-1:0]   data_qaddr_i,
    input  logic                   data_qwrite_i,
    input  logic [AmoWidth-1:0]    data_qamo_i,
    input  logic [DataWidth-1:0]   data_qdata_i,
    input  logic [DataWidth/8-1:0] data_qstrb_i,
    input  logic                   data_qvalid_i,
    output logic                   data_qready_o,
    output logic [DataWidth-1:0]   data_pdata_o,
    output logic                   data_perror_o,
    output logic                   data_pvalid_o,
    input  logic                   data_pready_i,
    output logic                   mem_valid_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic                   mem_write_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_wstrb_o,
    input  logic                   mem_ready_i,
    input  logic [DataWidth-1:0]   mem_rdata_i
);

    state_e state;
    logic   prio_data;
    logic   rsp_pending;
    logic   amo_req;
    logic   amo_accept;
    logic   data_elig;
    logic   sel_inst;
    logic   sel_data;
    logic   rsp_push;
    logic   [DataWidth-1:0] rsp_data;

    // A data request may only use memory when its response slot is (or is becoming) free.
    always_comb begin
        rsp_pending = data_pvalid_o && !data_pready_i;
        amo_req     = data_qvalid_i && (data_qamo_i != AmoNone);
        data_elig   = data_qvalid_i && !rsp_pending && !amo_req;
        amo_accept  = amo_req && !rsp_pending && (state != GNT_DATA);
        sel_inst    = 1'b0;
        sel_data    = 1'b0;
        case (state)
            IDLE: begin
                sel_data = data_elig && (!inst_valid_i || prio_data);
                sel_inst = inst_valid_i && !sel_data;
            end
            GNT_INST: sel_inst = 1'b1;
            GNT_DATA: sel_data = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        mem_valid_o   = sel_inst || sel_data;
        mem_addr_o    = '0;
        mem_write_o   = 1'b0;
        mem_wdata_o   = '0;
        mem_wstrb_o   = '0;
        inst_ready_o  = sel_inst && mem_ready_i;
        inst_data_o   = '0;
        data_qready_o = (sel_data && mem_ready_i) || amo_accept;
        if (sel_data) begin
            mem_addr_o  = data_qaddr_i;
            mem_write_o = data_qwrite_i;
            mem_wdata_o = data_qdata_i;
            mem_wstrb_o = data_qstrb_i;
        end else if (sel_inst) begin
            mem_addr_o  = inst_addr_i;
            inst_data_o = inst_addr_i[2] ? mem_rdata_i[DataWidth-1:InstWidth]
                                         : mem_rdata_i[InstWidth-1:0];
        end
    end

    // Stores and AMOs answer with zero data; only memory reads return rdata.
    assign rsp_push = data_qready_o;
    assign rsp_data = (sel_data && !data_qwrite_i) ? mem_rdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            prio_data <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_inst || sel_data) begin
                        if (mem_ready_i) prio_data <= sel_inst;
                        else             state     <= sel_inst ? GNT_INST : GNT_DATA;
                    end
                end
                GNT_INST: begin
                    if (mem_ready_i) begin
                        state     <= IDLE;
                        prio_data <= 1'b1;
                    end
                end
                GNT_DATA: begin
                    if (mem_ready_i) begin
                        state     <= IDLE;
                        prio_data <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    snitch_mem_rsp_reg #(
        .DataWidth (DataWidth)
    ) i_rsp_reg (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (rsp_push),
        .push_data  (rsp_data),
        .push_error (amo_accept),
        .pdata      (data_pdata_o),
        .perror     (data_perror_o),
        .pvalid     (data_pvalid_o),
        .pready     (data_pready_i)
    );

endmodule

// File: tb/tb_snitch_mem_arbiter.sv
// Directed plus random bench for snitch_mem_arbiter against a transaction-level model.
module tb_snitch_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic        inst_valid_i = 1'b0;
    logic [31:0] inst_data_o;
    logic        inst_ready_o;
    logic [31:0] data_qaddr_i = '0;
    logic        data_qwrite_i = 1'b0;
    logic [3:0]  data_qamo_i = '0;
    logic [63:0] data_qdata_i = '0;
    logic [7:0]  data_qstrb_i = '0;
    logic        data_qvalid_i = 1'b0;
    logic        data_qready_o;
    logic [63:0] data_pdata_o;
    logic        data_perror_o;
    logic        data_pvalid_o;
    logic        data_pready_i = 1'b0;
    logic        mem_valid_o;
    logic [31:0] mem_addr_o;
    logic        mem_write_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic        mem_ready_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;

    always #5 clk_i = ~clk_i;

    snitch_mem_arbiter dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .inst_addr_i   (inst_addr_i),
        .inst_valid_i  (inst_valid_i),
        .inst_data_o   (inst_data_o),
        .inst_ready_o  (inst_ready_o),
        .data_qaddr_i  (data_qaddr_i),
        .data_qwrite_i (data_qwrite_i),
        .data_qamo_i   (data_qamo_i),
        .data_qdata_i  (data_qdata_i),
        .data_qstrb_i  (data_qstrb_i),
        .data_qvalid_i (data_qvalid_i),
        .data_qready_o (data_qready_o),
        .data_pdata_o  (data_pdata_o),
        .data_perror_o (data_perror_o),
        .data_pvalid_o (data_pvalid_o),
        .data_pready_i (data_pready_i),
        .mem_valid_o   (mem_valid_o),
        .mem_addr_o    (mem_addr_o),
        .mem_write_o   (mem_write_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_wstrb_o   (mem_wstrb_o),
        .mem_ready_i   (mem_ready_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    int total = 0;
    int bad   = 0;

    // Requester transactions currently offered by the bench
    logic        i_act = 0;
    logic [31:0] i_addr = '0;
    logic        d_act = 0;
    logic [31:0] d_addr = '0;
    logic        d_write = 0;
    logic [3:0]  d_amo = '0;
    logic [63:0] d_wdata = '0;
    logic [7:0]  d_strb = '0;
    logic        mrdy = 0;
    logic [63:0] mrdata = '0;
    logic        prdy = 0;

    // Model: who holds the memory port (0 none, 1 fetch, 2 data), who was served last,
    // and the queue of responses owed to the data port.
    typedef struct {
        logic [63:0] data;
        logic        err;
    } rsp_t;
    rsp_t     rsp_q[$];
    int       owner = 0;
    int       last  = 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rsp_q.delete();
        owner = 0;
        last  = 1;
    endtask

    task automatic step();
        int     win;
        logic   pend;
        logic   amo_ok;
        logic   ielig;
        logic   delig;
        rsp_t   r;
        logic [63:0] e_idata;
        @(negedge clk_i);
        inst_valid_i  = i_act;
        inst_addr_i   = i_addr;
        data_qvalid_i = d_act;
        data_qaddr_i  = d_addr;
        data_qwrite_i = d_write;
        data_qamo_i   = d_amo;
        data_qdata_i  = d_wdata;
        data_qstrb_i  = d_strb;
        mem_ready_i   = mrdy;
        mem_rdata_i   = mrdata;
        data_pready_i = prdy;
        #1;
        pend  = (rsp_q.size() != 0) && !prdy;
        ielig = i_act;
        delig = d_act && !pend && (d_amo == 4'h0);
        if (owner != 0)         win = owner;
        else if (ielig && delig) win = (last == 2) ? 1 : 2;
        else if (delig)          win = 2;
        else if (ielig)          win = 1;
        else                     win = 0;
        amo_ok = d_act && (d_amo != 4'h0) && !pend && (owner != 2);
        e_idata = (win == 1) ? (i_addr[2] ? 64'(mrdata[63:32]) : 64'(mrdata[31:0])) : 64'h0;

        chk("mem_valid", 64'(mem_valid_o), 64'(win != 0));
        chk("mem_addr", 64'(mem_addr_o), (win == 1) ? 64'(i_addr) : (win == 2) ? 64'(d_addr) : 64'h0);
        chk("mem_write", 64'(mem_write_o), 64'((win == 2) && d_write));
        chk("mem_wdata", mem_wdata_o, (win == 2) ? d_wdata : 64'h0);
        chk("mem_wstrb", 64'(mem_wstrb_o), (win == 2) ? 64'(d_strb) : 64'h0);
        chk("inst_ready", 64'(inst_ready_o), 64'((win == 1) && mrdy));
        chk("inst_data", 64'(inst_data_o), e_idata);
        chk("data_qready", 64'(data_qready_o), 64'(((win == 2) && mrdy) || amo_ok));
        chk("data_pvalid", 64'(data_pvalid_o), 64'(rsp_q.size() != 0));
        if (rsp_q.size() != 0) begin
            chk("data_pdata", data_pdata_o, rsp_q[0].data);
            chk("data_perror", 64'(data_perror_o), 64'(rsp_q[0].err));
        end

        if (rsp_q.size() != 0 && prdy) void'(rsp_q.pop_front());
        if (win != 0 && mrdy) begin
            if (win == 1) begin
                i_act = 0;
                last  = 1;
            end else begin
                r.data = d_write ? 64'h0 : mrdata;
                r.err  = 1'b0;
                rsp_q.push_back(r);
                d_act = 0;
                last  = 2;
            end
            owner = 0;
        end else if (win != 0) begin
            owner = win;
        end
        if (amo_ok) begin
            r.data = 64'h0;
            r.err  = 1'b1;
            rsp_q.push_back(r);
            d_act = 0;
        end
        if (rsp_q.size() > 1) chk("rsp_depth", 64'(rsp_q.size()), 64'd1);
        @(posedge clk_i);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_i);
        rst_ni = 1'b0;
        i_act  = 0;
        d_act  = 0;
        inst_valid_i  = 1'b0;
        data_qvalid_i = 1'b0;
        repeat (n) @(posedge clk_i);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic new_data(input logic wr, input logic [31:0] a, input logic [3:0] amo);
        d_act   = 1;
        d_write = wr;
        d_addr  = a;
        d_amo   = amo;
        d_wdata = {$urandom, $urandom};
        d_strb  = 8'($urandom);
    endtask

    initial begin
        // Reset then idle
        do_reset(2);
        mrdy = 0; prdy = 1; mrdata = 64'h1234_5678_9ABC_DEF0;
        step();
        step();

        // Fetch alone with immediate ready, upper word selected
        i_act = 1; i_addr = 32'h0001_0004; mrdy = 1; mrdata = 64'hAAAA_BBBB_CCCC_DDDD;
        step();

        // Contention from reset: data first, then fetch, response held
        do_reset(1);
        prdy = 0;
        repeat (4) begin
            if (!i_act) begin i_act = 1; i_addr = $urandom & 32'hFFFF_FFFC; end
            if (!d_act) new_data(0, $urandom & 32'hFFFF_FFF8, 4'h0);
            mrdata = {$urandom, $urandom};
            step();
        end
        prdy = 1;
        repeat (4) begin
            if (!d_act) new_data(0, $urandom & 32'hFFFF_FFF8, 4'h0);
            mrdata = {$urandom, $urandom};
            step();
        end

        // Stalled memory with a late fetch request
        do_reset(1);
        prdy = 1; mrdy = 0;
        new_data(0, 32'h100, 4'h0);
        step();
        i_act = 1; i_addr = 32'h200;
        step();
        step();
        mrdy = 1; mrdata = 64'hFEED_0000_BEEF_0001;
        step();
        step();
        step();

        // Store under response backpressure, then pop together with a second store
        do_reset(1);
        prdy = 0; mrdy = 1;
        new_data(1, 32'h40, 4'h0);
        step();
        new_data(1, 32'h48, 4'h0);
        repeat (4) step();
        prdy = 1;
        step();
        step();

        // AMO bypasses memory and returns an error response
        do_reset(1);
        new_data(0, 32'h80, 4'h2);
        step();
        step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!i_act && ($urandom % 3 == 0)) begin
                i_act  = 1;
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_act && ($urandom % 3 == 0))
                new_data(1'($urandom), $urandom & 32'hFFFF_FFF8,
                         ($urandom % 8 == 0) ? 4'(($urandom % 15) + 1) : 4'h0);
            mrdy   = ($urandom % 4) != 0;
            prdy   = ($urandom % 3) != 0;
            mrdata = {$urandom, $urandom};
            step();
        end

        // Reset in the middle of a stalled grant with a pending response
        i_act = 1; i_addr = 32'h300; mrdy = 1; prdy = 0;
        if (!d_act) new_data(0, 32'h308, 4'h0);
        step();
        mrdy = 0;
        step();
        do_reset(1);
        mrdy = 1; prdy = 0;
        step();
        chk("post_reset_pvalid", 64'(data_pvalid_o), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snitch_mem_arbiter.md
Name: snitch_mem_arbiter

Overview:
- Merges the Snitch core's instruction-fetch port and data request/response port onto one shared 64-bit memory port.
- Sits directly downstream of the core, between the core and the test-harness memory model.
- Arbitrates round-robin between the two ports and holds a grant until the memory accepts the request.
- Converts same-cycle memory read data into the core's registered data response channel, with backpressure. At most one data response is outstanding.

Parameters:
- AddrWidth, 32, byte address width on all ports.
- DataWidth, 64, memory and data-port word width.
- InstWidth, 32, instruction word width; DataWidth/InstWidth must be 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset: synchronous, active-low; one clock.
- inst_addr_i  in  32  fetch address
- inst_valid_i  in  1  fetch request
- inst_data_o  out  32  fetched word
- inst_ready_o  out  1  fetch accepted/completed
- data_qaddr_i  in  32  data address
- data_qwrite_i  in  1  store when 1
- data_qamo_i  in  4  AMO opcode; 0 = none
- data_qdata_i  in  64  store data
- data_qstrb_i  in  8  byte strobes
- data_qvalid_i  in  1  data request
- data_qready_o  out  1  data request accepted
- data_pdata_o  out  64  response data
- data_perror_o  out  1  response error
- data_pvalid_o  out  1  response valid
- data_pready_i  in  1  response accepted
- mem_valid_o  out  1  memory request
- mem_addr_o  out  32  memory address
- mem_write_o  out  1  memory write
- mem_wdata_o  out  64  write data
- mem_wstrb_o  out  8  write strobes
- mem_ready_i  in  1  memory accepts; mem_rdata_i valid same cycle
- mem_rdata_i  in  64  read data

Behaviour:
Handshakes
- Memory request transfers on mem_valid_o && mem_ready_i.
- Requesters hold valid and payload stable until ready (valid/ready rule).

Grant state machine: IDLE, GNT_INST, GNT_DATA
- IDLE: eligible requesters are
  - inst_valid_i;
  - data_qvalid_i && !rsp_pending && data_qamo_i==0.
- IDLE with both eligible: winner is the port not served last (prio flop, reset = data first).
- Winner is driven to mem_* combinationally.
- If mem_ready_i is high the same cycle: transfer completes, state stays IDLE, prio flips to the other port.
- Otherwise: state moves to GNT_INST/GNT_DATA.
- GNT_x: drive port x only; no re-arbitration. On mem_ready_i: return to IDLE and flip prio.

Muxing
- inst_ready_o = mem_ready_i when inst is granted, else 0.
- inst_data_o = inst_addr_i[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0].
- mem_addr_o carries the full requester address.
- Inst grant: mem_write_o=0, mem_wstrb_o=0, mem_wdata_o=0.
- Idle outputs: mem_valid_o=0, mem_addr_o=0, mem_write_o=0, mem_wdata_o=0, mem_wstrb_o=0.

Data response
- Data acceptance (data_qready_o=1) registers one response, visible the next cycle.
  - Read: data_pdata_o = mem_rdata_i, perror=0.
  - Write: data_pdata_o = 0, perror=0.
- data_qamo_i != 0 with !rsp_pending:
  - no memory access; data_qready_o=1 immediately;
  - response: pdata=0, perror=1.
- Response is held until data_pvalid_o && data_pready_i.
- While rsp_pending, data_qready_o=0.
- Same-cycle pop and new accept is allowed: pvalid stays 1 with new contents.
- Every accepted data request yields exactly one response, in order.

Reset values (rst_ni low at a clock edge)
- Outputs: data_pvalid_o=0, data_pdata_o=0, data_perror_o=0.
- State: IDLE, prio=data.
- Reset mid-operation discards the pending grant and response.
- All combinational outputs are 0 while in IDLE with no requests.

Decomposition:
- Package snitch_mem_arbiter_pkg:
  - state enum {IDLE, GNT_INST, GNT_DATA};
  - AmoNone = 4'h0;
  - width constants.
- Optional sub-module snitch_mem_rsp_reg: one-entry response register with valid/ready, pop/push in the same cycle.
- The arbiter FSM stays in the top.

Test Plan:
- Reset then idle: rst_ni=0 for 2 cycles, no requests -> all outputs 0, state IDLE.
- Fetch alone, mem_ready_i=1, inst_addr_i=0x0001_0004, mem_rdata_i=0xAAAA_BBBB_CCCC_DDDD -> same cycle inst_ready_o=1, inst_data_o=0xAAAA_BBBB, mem_addr_o=0x0001_0004, mem_write_o=0.
- Contention after reset, both valid, mem_ready_i=1 every cycle -> grant order data, inst, data; data_qready_o=0 while its response is unpopped.
- Stalled memory: data read at 0x100, mem_ready_i low 3 cycles, inst_valid_i rising in cycle 1 -> mem_addr_o stays 0x100 until ready; then data_pvalid_o=1 next cycle with the sampled rdata.
- Backpressure: store accepted, data_pready_i=0 for 4 cycles -> pvalid held, pdata=0, second store not accepted; pop and second store in the same cycle -> pvalid stays 1.
- AMO: data_qamo_i=4'h2 -> mem_valid_o=0, data_qready_o=1; next cycle pvalid=1, perror=1, pdata=0.
